// File: rtl/mnemonic_uart_tx_if.sv
// rtl/mnemonic_uart_tx_if.sv - request/status bundle between the decoder and the mnemonic UART transmitter
interface mnemonic_uart_tx_if;
    logic [39:0] char_in;
    logic        char_valid;
    logic        ready;
    logic        busy;
    logic        dropped;

    modport master (
        output char_in,
        output char_valid,
        input  ready,
        input  busy,
        input  dropped
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output ready,
        output busy,
        output dropped
    );
endinterface

// File: rtl/mnemonic_uart_tx.sv
// rtl/mnemonic_uart_tx.sv - serialises a 5-character mnemonic (plus optional CR/LF) over an 8N1 UART line
module mnemonic_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit SEND_CRLF    = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    mnemonic_uart_tx_if.slave bus,
    output logic              tx
);

    localparam int             BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BYTE_LAST = SEND_CRLF ? 3'd6 : 3'd4;

    // A bit period shorter than two clocks leaves no room for the baud counter
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("mnemonic_uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [39:0]   hold;
    logic [7:0]    shreg;
    logic          ready_r;
    logic          dropped_r;
    logic          tx_r;
    logic [7:0]    cur_byte;
    logic          baud_end;

    // Byte selected for the frame being started: five characters, then CR, LF
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            3'd0:    cur_byte = hold[39:32];
            3'd1:    cur_byte = hold[31:24];
            3'd2:    cur_byte = hold[23:16];
            3'd3:    cur_byte = hold[15:8];
            3'd4:    cur_byte = hold[7:0];
            3'd5:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign baud_end = (baud == BAUD_LAST);

    // Framing FSM; every output is registered so tx has no path from the inputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 3'd0;
            hold      <= 40'h0;
            shreg     <= 8'h00;
            ready_r   <= 1'b1;
            dropped_r <= 1'b0;
            tx_r      <= 1'b1;
        end else begin
            dropped_r <= bus.char_valid && !ready_r;
            case (state)
                IDLE: begin
                    if (bus.char_valid) begin
                        // Start bit of the first byte begins on the accept edge
                        hold     <= bus.char_in;
                        tx_r     <= 1'b0;
                        ready_r  <= 1'b0;
                        baud     <= '0;
                        byte_idx <= 3'd0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        tx_r    <= cur_byte[0];
                        shreg   <= {1'b0, cur_byte[7:1]};
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_r  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_r    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            // Line is already high from the stop bit
                            ready_r <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap
                            byte_idx <= byte_idx + 3'd1;
                            tx_r     <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.busy    = ~ready_r;
    assign bus.dropped = dropped_r;
    assign tx          = tx_r;

endmodule
